// File: rtl/multi_channel_adc_sampler.sv
// Multi-channel ADC sampler: divides clk to a sampling tick, snapshots all channels,
// and streams the snapshot one channel per valid/ready beat with overrun detection.
module multi_channel_adc_sampler #(
    parameter int unsigned CLK_FREQ    = 100000000,
    parameter int unsigned TARGET_FREQ = 256,
    parameter int unsigned NUM_CH      = 8,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned FRAME_W     = 16,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     clr_ovr,
    input  logic [NUM_CH*DATA_W-1:0] adc_in,
    output logic                     sample_clk,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_W-1:0]        m_data,
    output logic [CH_W-1:0]          m_ch,
    output logic                     m_last,
    output logic [FRAME_W-1:0]       frame_cnt,
    output logic                     overrun
);

    localparam int unsigned DIV   = CLK_FREQ / TARGET_FREQ;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  counter;
    logic [DATA_W-1:0] snap [NUM_CH];
    logic              tick;
    logic              hs;
    logic              last_hs;
    logic              capture;
    logic              advance;
    logic              ovr_set;
    logic [CH_W-1:0]   ch_nxt;

    // Sampling divider and its square-wave view
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter    <= '0;
            sample_clk <= 1'b0;
        end else begin
            if (!en || (counter == CNT_W'(DIV - 1))) begin
                counter <= '0;
            end else begin
                counter <= counter + CNT_W'(1);
            end
            sample_clk <= en && (counter < CNT_W'(DIV / 2));
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a tick coinciding with the last handshake keeps us in SEND
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (capture) state_nxt = SEND;
            SEND:    if (last_hs && !capture) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control strobes
    always_comb begin
        tick    = en && (counter == CNT_W'(DIV - 1));
        hs      = m_valid && m_ready;
        last_hs = hs && m_last;
        capture = tick && ((state == IDLE) || last_hs);
        advance = hs && !m_last;
        ovr_set = tick && (state == SEND) && !last_hs;
        ch_nxt  = m_ch + CH_W'(1);
    end

    assign m_valid = (state == SEND);

    // Snapshot, beat registers, frame counter and sticky overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                snap[k] <= '0;
            end
            m_data    <= '0;
            m_ch      <= '0;
            m_last    <= 1'b0;
            frame_cnt <= '0;
            overrun   <= 1'b0;
        end else begin
            if (capture) begin
                for (int unsigned k = 0; k < NUM_CH; k++) begin
                    snap[k] <= adc_in[k*DATA_W +: DATA_W];
                end
                m_data    <= adc_in[DATA_W-1:0];
                m_ch      <= '0;
                m_last    <= (NUM_CH == 1);
                frame_cnt <= frame_cnt + FRAME_W'(1);
            end else if (advance) begin
                m_data <= snap[ch_nxt];
                m_ch   <= ch_nxt;
                m_last <= (ch_nxt == CH_W'(NUM_CH - 1));
            end else if (last_hs) begin
                m_data <= '0;
                m_ch   <= '0;
                m_last <= 1'b0;
            end

            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_multi_channel_adc_sampler.sv
// Scoreboard bench for multi_channel_adc_sampler: a frame-level model predicts beats,
// a negedge monitor pops and compares them alongside the per-cycle status outputs.
module tb_multi_channel_adc_sampler;

    localparam int unsigned CLK_FREQ    = 1000;
    localparam int unsigned TARGET_FREQ = 100;
    localparam int unsigned DIV         = CLK_FREQ / TARGET_FREQ;
    localparam int unsigned NUM_CH      = 4;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned FRAME_W     = 16;
    localparam int unsigned CH_W        = 2;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [CH_W-1:0]   ch;
        logic              last;
    } beat_t;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     en;
    logic                     clr_ovr;
    logic [NUM_CH*DATA_W-1:0] adc_in;
    logic                     sample_clk;
    logic                     m_valid;
    logic                     m_ready;
    logic [DATA_W-1:0]        m_data;
    logic [CH_W-1:0]          m_ch;
    logic                     m_last;
    logic [FRAME_W-1:0]       frame_cnt;
    logic                     overrun;

    int vectors = 0;
    int errors  = 0;

    // Reference model state
    int                 md_phase;
    int                 md_left;
    logic               md_ovr;
    logic [FRAME_W-1:0] md_frames;
    logic               md_sclk;
    beat_t              exp_q[$];

    multi_channel_adc_sampler #(
        .CLK_FREQ   (CLK_FREQ),
        .TARGET_FREQ(TARGET_FREQ),
        .NUM_CH     (NUM_CH),
        .DATA_W     (DATA_W),
        .FRAME_W    (FRAME_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .clr_ovr   (clr_ovr),
        .adc_in    (adc_in),
        .sample_clk(sample_clk),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_ch      (m_ch),
        .m_last    (m_last),
        .frame_cnt (frame_cnt),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: a frame is accepted on a tick whenever no beats remain or
    // the final beat is being taken; otherwise the tick is an overrun.
    initial begin
        bit    tick;
        bit    hs;
        bit    accept;
        beat_t b;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                md_phase  = 0;
                md_left   = 0;
                md_ovr    = 1'b0;
                md_frames = '0;
                md_sclk   = 1'b0;
                exp_q.delete();
            end else begin
                tick    = en && (md_phase == DIV - 1);
                hs      = (md_left > 0) && m_ready;
                accept  = tick && ((md_left == 0) || (hs && md_left == 1));
                md_sclk = en && (md_phase < DIV / 2);
                if (accept) begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        b.d    = adc_in[k*DATA_W +: DATA_W];
                        b.ch   = CH_W'(k);
                        b.last = (k == NUM_CH - 1);
                        exp_q.push_back(b);
                    end
                    md_left   = NUM_CH;
                    md_frames = md_frames + 1'b1;
                end else if (hs) begin
                    md_left = md_left - 1;
                end
                if (tick && !accept) md_ovr = 1'b1;
                else if (clr_ovr)    md_ovr = 1'b0;
                md_phase = en ? (md_phase + 1) % DIV : 0;
            end
        end
    end

    // Monitor: compares status every cycle and pops a beat on each handshake
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("m_valid", 32'(m_valid), 32'(md_left > 0));
                chk("overrun", 32'(overrun), 32'(md_ovr));
                chk("frame_cnt", 32'(frame_cnt), 32'(md_frames));
                chk("sample_clk", 32'(sample_clk), 32'(md_sclk));
                if (m_valid) begin
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL beat_unexpected: got data 0x%0h ch %0d, expected no beat", m_data, m_ch);
                    end else begin
                        b = exp_q[0];
                        chk("m_data", 32'(m_data), 32'(b.d));
                        chk("m_ch", 32'(m_ch), 32'(b.ch));
                        chk("m_last", 32'(m_last), 32'(b.last));
                        if (m_ready) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_phase(input int ph);
        int n = 0;
        while (md_phase != ph && n < 3 * DIV) begin
            step(1);
            n++;
        end
        if (md_phase != ph) begin
            errors++;
            $display("FAIL phase_wait: got phase %0d, expected %0d", md_phase, ph);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_sample_clk"}, 32'(sample_clk), 32'd0);
        chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        chk({tag, "_m_data"}, 32'(m_data), 32'd0);
        chk({tag, "_m_ch"}, 32'(m_ch), 32'd0);
        chk({tag, "_m_last"}, 32'(m_last), 32'd0);
        chk({tag, "_overrun"}, 32'(overrun), 32'd0);
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    endtask

    initial begin
        int sclk_hi;
        int valid_hi;
        int thr;
        rst_n   = 1'b0;
        en      = 1'b0;
        clr_ovr = 1'b0;
        m_ready = 1'b0;
        adc_in  = '0;
        step(3);
        chk_zero_outputs("reset");
        rst_n = 1'b1;
        step(2);

        // Divider and steady streaming
        adc_in  = 64'h1234_5678_9abc_def0;
        en      = 1'b1;
        m_ready = 1'b1;
        step(25);
        sclk_hi  = 0;
        valid_hi = 0;
        for (int i = 0; i < DIV; i++) begin
            sclk_hi  += int'(sample_clk);
            valid_hi += int'(m_valid);
            step(1);
        end
        chk("sclk_high_per_period", 32'(sclk_hi), 32'(DIV / 2));
        chk("valid_per_period", 32'(valid_hi), 32'(NUM_CH));

        // Capture order with bus changing right after the tick
        wait_phase(DIV - 1);
        adc_in = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        step(1);
        adc_in = {$urandom, $urandom};
        step(DIV);

        // Backpressure on ch1
        wait_phase(1);
        m_ready = 1'b0;
        step(3);
        m_ready = 1'b1;
        step(2 * DIV);

        // Overrun: stall across a tick, then clear
        wait_phase(0);
        m_ready = 1'b0;
        step(12);
        m_ready = 1'b1;
        step(2 * DIV);
        clr_ovr = 1'b1;
        step(1);
        clr_ovr = 1'b0;
        step(3);

        // Last handshake landing on the tick
        for (int i = 0; i < 4 * DIV; i++) begin
            m_ready = (md_phase >= 6);
            adc_in  = {$urandom, $urandom};
            step(1);
        end
        m_ready = 1'b1;
        step(DIV);

        // Asynchronous reset during beat ch2
        wait_phase(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("async_reset");
        step(2);
        rst_n = 1'b1;
        step(2 * DIV);

        // Enable dropped mid-frame
        wait_phase(1);
        en = 1'b0;
        step(2 * DIV);
        en = 1'b1;

        // Randomised traffic
        for (int i = 0; i < 1600; i++) begin
            case ((i / 200) % 4)
                0:       thr = 100;
                1:       thr = 70;
                2:       thr = 40;
                default: thr = 15;
            endcase
            m_ready = ($urandom_range(0, 99) < thr);
            adc_in  = {$urandom, $urandom};
            clr_ovr = ($urandom_range(0, 49) == 0);
            en      = ($urandom_range(0, 399) != 0);
            step(1);
        end

        en      = 1'b0;
        clr_ovr = 1'b0;
        m_ready = 1'b1;
        step(3 * DIV);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
